// File: rtl/core_pkg.sv
// Shared load definitions: funct3 encodings, FSM state type, legality and size helpers.
package core_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    // ld and lwu only exist on a 64-bit datapath.
    function automatic logic funct3_legal(input logic [2:0] f3, input int xlen);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            F3_LD, F3_LWU:                       return (xlen == 64);
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational shift/extend of a {hi,lo} beat pair by byte offset and load funct3.
// LOAD_MISALIGN_EN: when undefined, any offset not a multiple of the access size faults.
module load_extend
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           hi,
    input  logic [XLEN-1:0]           lo,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [2:0]                funct3,
    output logic [XLEN-1:0]           data,
    output logic                      fault
);
    localparam int IDX_W = $clog2(XLEN);

    logic [3:0]       size;
    logic [6:0]       field_bits;
    logic [IDX_W-1:0] sign_idx;
    logic [XLEN-1:0]  low;
    logic [XLEN-1:0]  mask;
    logic             sign;
    logic             legal;

    assign size       = size_bytes(funct3);
    assign field_bits = {size, 3'b000};
    assign sign_idx   = IDX_W'(field_bits - 7'd1);
    assign low        = XLEN'({hi, lo} >> {offset, 3'b000});
    assign legal      = funct3_legal(funct3, XLEN);
    assign sign       = !funct3[2] && low[sign_idx];

    // A full-width field sets every mask bit, so ~mask is zero and nothing is filled.
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_mask
        assign mask[gi] = (7'(gi) < field_bits);
    end

`ifdef LOAD_MISALIGN_EN
    assign fault = !legal;
`else
    logic [3:0] off_ext;
    assign off_ext = 4'(offset);
    assign fault   = !legal || (|(off_ext & (size - 4'd1)));
`endif

    assign data = fault ? '0 : ((low & mask) | (sign ? ~mask : '0));

endmodule

// File: rtl/load_align_unit.sv
// Load-return unit: beat capture, optional two-beat assembly FSM, single-stage output register.
// LOAD_MISALIGN_EN: enables in-word misaligned loads and the IDLE->HOLD->IDLE spanning path.
module load_align_unit
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic [OFF_W-1:0] in_offset,
    input  logic [2:0]      in_funct3,
    input  logic [RD_W-1:0] in_rd,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_fault
);
    logic            accept;
    logic            load_out;
    logic            ext_fault;
    logic [XLEN-1:0] beat_hi;
    logic [XLEN-1:0] beat_lo;
    logic [XLEN-1:0] ext_data;

    assign in_ready = !wb_valid || wb_ready;
    assign accept   = in_valid && in_ready;

`ifdef LOAD_MISALIGN_EN
    state_t          state_reg;
    state_t          state_next;
    logic [XLEN-1:0] lo_reg;
    logic            span;
    logic            capture_lo;

    assign span    = (5'(in_offset) + 5'(size_bytes(in_funct3))) > 5'(XLEN / 8);
    assign beat_hi = (state_reg == ST_HOLD) ? in_data : '0;
    assign beat_lo = (state_reg == ST_HOLD) ? lo_reg : in_data;

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && span && !ext_fault) state_next = ST_HOLD;
            ST_HOLD: if (accept) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Faulting spanning loads never enter HOLD; they retire in one beat.
    always_comb begin
        capture_lo = 1'b0;
        load_out   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                capture_lo = accept && span && !ext_fault;
                load_out   = accept && !(span && !ext_fault);
            end
            ST_HOLD: load_out = accept;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)          lo_reg <= '0;
        else if (capture_lo) lo_reg <= in_data;
    end
`else
    assign beat_hi  = '0;
    assign beat_lo  = in_data;
    assign load_out = accept;
`endif

    load_extend #(.XLEN(XLEN)) u_extend (
        .hi     (beat_hi),
        .lo     (beat_lo),
        .offset (in_offset),
        .funct3 (in_funct3),
        .data   (ext_data),
        .fault  (ext_fault)
    );

    // A new result takes priority over consumption of the old one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_fault <= 1'b0;
        end else if (load_out) begin
            wb_valid <= 1'b1;
            wb_data  <= ext_data;
            wb_rd    <= in_rd;
            wb_fault <= ext_fault;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

endmodule
